// File: rtl/dclk_tx_pkg.sv
// dclk_tx_pkg: flit geometry and transmitter state encodings shared by dclk_tx and its bench
package dclk_tx_pkg;
  localparam int HDR_SZ = 2;
  localparam int PL_SZ = 8;
  localparam int ADDR_SZ = 4;
  localparam int FLIT_W = HDR_SZ + PL_SZ + ADDR_SZ;
  typedef enum logic [1:0] {
    TX_STATE_IDLE = 2'd0,
    TX_STATE_SEND = 2'd1,
    TX_STATE_WAIT = 2'd2
  } tx_state_e;
endpackage

// File: rtl/dclk_tx_if.sv
// dclk_tx_if: valid/ready flit handshake from the router output stage into dclk_tx
interface dclk_tx_if import dclk_tx_pkg::*; #(parameter int W = FLIT_W);
  logic [W-1:0] data_in;
  logic data_valid;
  logic data_ready;
  modport master(output data_in, data_valid, input data_ready);
  modport slave(input data_in, data_valid, output data_ready);
endinterface

// File: rtl/dclk_tx_hold.sv
// dclk_tx_hold: single-entry flit buffer with valid/ready on both sides
module dclk_tx_hold #(parameter int W = 8) (
  input  logic         wclk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic full_q, full_d, push, pop;
  logic [W-1:0] data_q, data_d;
  always_ff @(posedge wclk or negedge reset)
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  always_comb begin
    in_ready = !full_q;
    out_valid = full_q;
    out_data = data_q;
    push = in_valid && in_ready;
    pop = full_q && out_ready;
    full_d = push || (full_q && !pop);
    data_d = push ? in_data : data_q;
  end
endmodule

// File: rtl/dclk_tx.sv
// dclk_tx: serialises router flits into dclk_rx frames (start bit, data LSB first, trailer 0)
// Define DCLK_TX_BUF_EN to put a one-flit holding register (dclk_tx_hold) in front of the shifter.
module dclk_tx import dclk_tx_pkg::*; #(
  parameter string port = "unknown",
  parameter int DATA_W = FLIT_W
) (
  input  logic     wclk,
  input  logic     reset,
  dclk_tx_if.slave flit,
  input  logic     channel_busy,
  output logic     serial_out,
  output logic     tx_active
);
  localparam int CW = $clog2(DATA_W + 1);
  tx_state_e state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, src_data;
  logic [CW-1:0] cnt_q, cnt_d;
  logic so_q, so_d, src_valid, start_ready, start, last, sending;
  assign start_ready = state_q == TX_STATE_IDLE && !channel_busy;
  assign start = src_valid && start_ready;
  assign last = cnt_q == CW'(DATA_W);
  assign sending = state_q == TX_STATE_SEND && !last;
`ifdef DCLK_TX_BUF_EN
  logic hold_ready;
  dclk_tx_hold #(.W(DATA_W)) u_hold (
    .wclk      (wclk),
    .reset     (reset),
    .in_data   (flit.data_in),
    .in_valid  (flit.data_valid),
    .in_ready  (hold_ready),
    .out_data  (src_data),
    .out_valid (src_valid),
    .out_ready (start_ready)
  );
  assign flit.data_ready = reset && hold_ready;
`else
  assign src_data = flit.data_in;
  assign src_valid = flit.data_valid;
  assign flit.data_ready = reset && start_ready;
`endif
  always_ff @(posedge wclk or negedge reset)
    if (!reset) begin
      state_q <= TX_STATE_IDLE;
      shift_q <= '0;
      cnt_q <= '0;
      so_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      so_q <= so_d;
    end
  always_comb begin
    state_d = start ? TX_STATE_SEND
            : (state_q == TX_STATE_SEND && last) ? TX_STATE_WAIT
            : (state_q == TX_STATE_WAIT && !channel_busy) ? TX_STATE_IDLE
            : state_q;
  end
  // the trailer cycle (cnt==W) drives 0 because sending is already false there
  always_comb begin
    shift_d = start ? src_data : sending ? shift_q >> 1 : shift_q;
    cnt_d = start ? '0 : sending ? cnt_q + 1'b1 : cnt_q;
    so_d = start || (sending && shift_q[0]);
    serial_out = so_q;
    tx_active = state_q == TX_STATE_SEND;
  end
`ifndef SYNTHESIS
  always @(posedge wclk)
    if (reset) assert (state_q == TX_STATE_SEND || !so_q)
      else $error("dclk_tx %s: stray 1 on serial_out outside a frame", port);
`endif
endmodule

// File: tb/tb_dclk_tx.sv
// tb_dclk_tx: randomized bench comparing dclk_tx against a queue-of-bits frame model and a negedge deserializer
module tb_dclk_tx;
  import dclk_tx_pkg::*;
  localparam int W = FLIT_W;
  logic wclk = 1'b0, reset = 1'b0, channel_busy = 1'b0;
  logic serial_out, tx_active;
  dclk_tx_if #(.W(W)) flit();
  dclk_tx #(.port("tb"), .DATA_W(W)) dut (
    .wclk         (wclk),
    .reset        (reset),
    .flit         (flit),
    .channel_busy (channel_busy),
    .serial_out   (serial_out),
    .tx_active    (tx_active)
  );
  always #5 wclk = ~wclk;
  int vectors = 0, miscompares = 0;
  bit m_q[$];
  bit m_wait = 1'b0, m_so = 1'b0, m_hold_full = 1'b0, entered_wait = 1'b0, last_acc = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic [W-1:0] sent_q[$];
  int rx_cnt = 0;
  int rx_n = -1;
  logic [W-1:0] rx_sh = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    return m_q.size() == 0 && !m_wait;
  endfunction

  function automatic bit m_ready();
`ifdef DCLK_TX_BUF_EN
    return reset && !m_hold_full;
`else
    return reset && m_idle() && !channel_busy;
`endif
  endfunction

  // advance the model by one posedge using the inputs that were stable before it
  task automatic m_step();
    bit v = flit.data_valid;
    bit b = channel_busy;
    bit idle = m_idle();
    bit pre_full = m_hold_full;
    logic [W-1:0] d = flit.data_in;
    bit sv;
    logic [W-1:0] sd;
`ifdef DCLK_TX_BUF_EN
    sv = m_hold_full;
    sd = m_hold;
`else
    sv = v;
    sd = d;
`endif
    entered_wait = 1'b0;
    if (m_wait && !b) m_wait = 1'b0;
    if (m_q.size() > 0) begin
      m_so = m_q.pop_front();
      if (m_q.size() == 0) begin
        m_wait = 1'b1;
        entered_wait = 1'b1;
      end
    end else if (idle && !b && sv) begin
      m_so = 1'b1;
      sent_q.push_back(sd);
      for (int i = 0; i < W; i++) m_q.push_back(sd[i]);
      m_q.push_back(1'b0);
      m_hold_full = 1'b0;
    end else m_so = 1'b0;
`ifdef DCLK_TX_BUF_EN
    if (v && !pre_full) begin
      m_hold_full = 1'b1;
      m_hold = d;
    end
`endif
  endtask

  task automatic cycle(bit nv, logic [W-1:0] nd, bit nb);
    last_acc = flit.data_valid && flit.data_ready;
    @(posedge wclk);
    m_step();
    if (rx_cnt > 0) rx_cnt--;
    if (entered_wait) rx_cnt = $urandom_range(1, 4);
    #1;
    flit.data_valid = nv;
    flit.data_in = nd;
    channel_busy = nb || rx_cnt > 0;
    #1;
    check("serial_out", 32'(serial_out), 32'(m_so));
    check("tx_active", 32'(tx_active), 32'(m_q.size() > 0));
    check("data_ready", 32'(flit.data_ready), 32'(m_ready()));
  endtask

  // captures one whole frame from its start bit; bit k of the trace is line cycle k
  task automatic frame_trace(string name, logic [W-1:0] d, logic [31:0] exp);
    logic [31:0] tr = '0;
    bit found = 1'b0;
    cycle(1'b1, d, 1'b0);
    for (int k = 0; k < 8 && !found; k++) begin
      cycle(1'b0, '0, 1'b0);
      found = serial_out;
    end
    check({name, "_start"}, 32'(found), 32'd1);
    if (found) begin
      tr[0] = 1'b1;
      for (int k = 1; k < W + 2; k++) begin
        cycle(1'b0, '0, 1'b0);
        tr[k] = serial_out;
      end
    end
    check(name, tr, exp);
    repeat (8) cycle(1'b0, '0, 1'b0);
  endtask

  // independent receiver: samples on negedge like dclk_rx and checks delivered data
  always @(negedge wclk) begin
    if (!reset) rx_n = -1;
    else if (rx_n < 0) begin
      if (serial_out) rx_n = 0;
    end else if (rx_n < W) begin
      rx_sh[rx_n] = serial_out;
      rx_n++;
    end else begin
      check("rx_trailer", 32'(serial_out), 32'd0);
      if (sent_q.size() == 0) check("rx_unexpected_frame", 32'd1, 32'd0);
      else check("rx_data", 32'(rx_sh), 32'(sent_q.pop_front()));
      rx_n = -1;
    end
  end

  initial begin
    logic [W-1:0] bd;
    flit.data_valid = 1'b0;
    flit.data_in = '0;
    repeat (3) @(posedge wclk);
    #2;
    check("reset_serial_out", 32'(serial_out), 32'd0);
    check("reset_tx_active", 32'(tx_active), 32'd0);
    check("reset_data_ready", 32'(flit.data_ready), 32'd0);
    @(negedge wclk) reset = 1'b1;
    repeat (2) cycle(1'b0, '0, 1'b0);
    frame_trace("frame_bit0", 14'h0001, 32'h0003);
    frame_trace("frame_ones", 14'h3FFF, 32'h7FFF);
    frame_trace("frame_alt", 14'h1555, 32'h2AAB);
    bd = W'($urandom);
    repeat (10) cycle(1'b1, bd, 1'b1);
    cycle(1'b1, bd, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("busy_release_start", 32'(serial_out), 32'd1);
    repeat (W + 8) cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      bit nv;
      logic [W-1:0] nd;
      if (!flit.data_valid || last_acc) begin
        nv = $urandom_range(0, 3) != 0;
        nd = W'($urandom);
      end else begin
        nv = 1'b1;
        nd = flit.data_in;
      end
      cycle(nv, nd, $urandom_range(0, 15) == 0);
      last_acc = flit.data_valid && flit.data_ready;
    end
    cycle(1'b0, '0, 1'b0);
    repeat (W + 8) cycle(1'b0, '0, 1'b0);
    check("all_frames_delivered", 32'(sent_q.size()), 32'd0);
    frame_trace("pre_reset_frame", 14'h0F0F, 32'h1E1F);
    cycle(1'b1, 14'h2AAA, 1'b0);
    for (int k = 0; k < 8 && !serial_out; k++) cycle(1'b0, '0, 1'b0);
    repeat (W / 2) cycle(1'b0, '0, 1'b0);
    check("midframe_active", 32'(tx_active), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_reset_serial_out", 32'(serial_out), 32'd0);
    check("async_reset_tx_active", 32'(tx_active), 32'd0);
    check("async_reset_data_ready", 32'(flit.data_ready), 32'd0);
    m_q.delete();
    sent_q.delete();
    m_wait = 1'b0;
    m_so = 1'b0;
    m_hold_full = 1'b0;
    rx_cnt = 0;
    channel_busy = 1'b0;
    flit.data_valid = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk) reset = 1'b1;
    frame_trace("post_reset_frame", 14'h03C3, 32'h0787);
    check("post_reset_delivered", 32'(sent_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
